// File: rtl/dag_circ_top.sv
// Data address generator with two register banks (bank 0 -> DM, bank 1 -> PM).
// Each bank holds NREG index/modify/length/base registers. Addresses support
// circular-buffer wrap, an immediate modifier and bit-reversed output. The
// register file is read and written from the bus.
module dag_circ_top #(
    parameter int AW   = 16,
    parameter int NREG = 8,
    parameter int IW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ps_dg_en,
    input  logic            ps_dg_dgsclt,
    input  logic            ps_dg_mdfy,
    input  logic [IW-1:0]   ps_dg_iadd,
    input  logic [IW-1:0]   ps_dg_madd,
    input  logic            ps_dg_imm_en,
    input  logic [AW-1:0]   ps_dg_imm,
    input  logic            ps_dg_brev,
    input  logic            ps_dg_wrt_en,
    input  logic [IW+2:0]   ps_dg_wrt_add,
    input  logic [IW+2:0]   ps_dg_rd_add,
    input  logic [AW-1:0]   bc_dt_out,
    output logic [AW-1:0]   dg_bc_dt,
    output logic [AW-1:0]   dg_dm_add,
    output logic            dg_dm_vld,
    output logic [AW-1:0]   dg_pm_add,
    output logic            dg_pm_vld
);

    localparam logic [1:0] T_M = 2'b00;
    localparam logic [1:0] T_I = 2'b01;
    localparam logic [1:0] T_L = 2'b10;
    localparam logic [1:0] T_B = 2'b11;

    logic [AW-1:0] m_reg [2][NREG];
    logic [AW-1:0] i_reg [2][NREG];
    logic [AW-1:0] l_reg [2][NREG];
    logic [AW-1:0] b_reg [2][NREG];

    logic [1:0]    wrt_type;
    logic          wrt_bank;
    logic [IW-1:0] wrt_idx;
    logic [1:0]    rd_type;
    logic          rd_bank;
    logic [IW-1:0] rd_idx;

    logic [AW-1:0] i_cur;
    logic [AW-1:0] l_cur;
    logic [AW-1:0] b_cur;
    logic [AW-1:0] mod;
    logic [AW:0]   sum;
    logic [AW:0]   lim;
    logic [AW-1:0] wrap_val;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_out;
    logic          i_wrt_hit;

    assign {wrt_type, wrt_bank, wrt_idx} = ps_dg_wrt_add;
    assign {rd_type, rd_bank, rd_idx}    = ps_dg_rd_add;

    // Modifier selection, AW+1-bit sum and single-step circular correction.
    // Only the low AW bits of a corrected sum are kept, so the correction is
    // done at AW bits; the carry bit only matters for the limit compares.
    always_comb begin
        i_cur    = i_reg[ps_dg_dgsclt][ps_dg_iadd];
        l_cur    = l_reg[ps_dg_dgsclt][ps_dg_iadd];
        b_cur    = b_reg[ps_dg_dgsclt][ps_dg_iadd];
        mod      = ps_dg_imm_en ? ps_dg_imm : m_reg[ps_dg_dgsclt][ps_dg_madd];
        sum      = {1'b0, i_cur} + {mod[AW-1], mod};
        lim      = {1'b0, b_cur} + {1'b0, l_cur};
        wrap_val = sum[AW-1:0];
        if (l_cur != '0) begin
            if (!mod[AW-1] && (sum >= lim))
                wrap_val = sum[AW-1:0] - l_cur;
            else if (mod[AW-1] && (sum < {1'b0, b_cur}))
                wrap_val = sum[AW-1:0] + l_cur;
        end
    end

    // Premodify emits the wrapped address, postmodify emits the current I;
    // bit reversal applies to the emitted address only.
    always_comb begin
        addr     = ps_dg_mdfy ? wrap_val : i_cur;
        addr_out = addr;
        if (ps_dg_brev) begin
            for (int n = 0; n < AW; n++)
                addr_out[n] = addr[AW-1-n];
        end
    end

    // A bus write to the same I (directly or through a B write) beats the
    // postmodify update.
    assign i_wrt_hit = ps_dg_wrt_en && (wrt_type == T_I || wrt_type == T_B) &&
                       (wrt_bank == ps_dg_dgsclt) && (wrt_idx == ps_dg_iadd);

    // Register-file read with write-through bypass on exact address match.
    always_comb begin
        case (rd_type)
            T_M:     dg_bc_dt = m_reg[rd_bank][rd_idx];
            T_I:     dg_bc_dt = i_reg[rd_bank][rd_idx];
            T_L:     dg_bc_dt = l_reg[rd_bank][rd_idx];
            default: dg_bc_dt = b_reg[rd_bank][rd_idx];
        endcase
        if (ps_dg_wrt_en && (ps_dg_wrt_add == ps_dg_rd_add))
            dg_bc_dt = bc_dt_out;
    end

    // Register file: postmodify update and bus writes; B writes also reload I.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int n = 0; n < NREG; n++) begin
                    m_reg[b][n] <= '0;
                    i_reg[b][n] <= '0;
                    l_reg[b][n] <= '0;
                    b_reg[b][n] <= '0;
                end
            end
        end else begin
            if (ps_dg_en && !ps_dg_mdfy && !i_wrt_hit)
                i_reg[ps_dg_dgsclt][ps_dg_iadd] <= wrap_val;
            if (ps_dg_wrt_en) begin
                case (wrt_type)
                    T_M: m_reg[wrt_bank][wrt_idx] <= bc_dt_out;
                    T_I: i_reg[wrt_bank][wrt_idx] <= bc_dt_out;
                    T_L: l_reg[wrt_bank][wrt_idx] <= bc_dt_out;
                    default: begin
                        b_reg[wrt_bank][wrt_idx] <= bc_dt_out;
                        i_reg[wrt_bank][wrt_idx] <= bc_dt_out;
                    end
                endcase
            end
        end
    end

    // Registered address outputs; unselected bank holds with vld low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dg_dm_add <= '0;
            dg_pm_add <= '0;
            dg_dm_vld <= 1'b0;
            dg_pm_vld <= 1'b0;
        end else begin
            dg_dm_vld <= ps_dg_en && !ps_dg_dgsclt;
            dg_pm_vld <= ps_dg_en && ps_dg_dgsclt;
            if (ps_dg_en && !ps_dg_dgsclt)
                dg_dm_add <= addr_out;
            if (ps_dg_en && ps_dg_dgsclt)
                dg_pm_add <= addr_out;
        end
    end

endmodule

// File: tb/tb_dag_circ_top.sv
// Directed bench for dag_circ_top: reset, circular wrap, immediate modifier,
// linear mode, bit reversal, write/postmodify collision and read bypass.
module tb_dag_circ_top;

    localparam int AW   = 16;
    localparam int NREG = 8;
    localparam int IW   = 3;

    localparam logic [1:0] T_M = 2'b00;
    localparam logic [1:0] T_I = 2'b01;
    localparam logic [1:0] T_L = 2'b10;
    localparam logic [1:0] T_B = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ps_dg_en;
    logic            ps_dg_dgsclt;
    logic            ps_dg_mdfy;
    logic [IW-1:0]   ps_dg_iadd;
    logic [IW-1:0]   ps_dg_madd;
    logic            ps_dg_imm_en;
    logic [AW-1:0]   ps_dg_imm;
    logic            ps_dg_brev;
    logic            ps_dg_wrt_en;
    logic [IW+2:0]   ps_dg_wrt_add;
    logic [IW+2:0]   ps_dg_rd_add;
    logic [AW-1:0]   bc_dt_out;
    logic [AW-1:0]   dg_bc_dt;
    logic [AW-1:0]   dg_dm_add;
    logic            dg_dm_vld;
    logic [AW-1:0]   dg_pm_add;
    logic            dg_pm_vld;

    int n_tests = 0;
    int n_fail  = 0;

    dag_circ_top #(.AW(AW), .NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n),
        .ps_dg_en(ps_dg_en), .ps_dg_dgsclt(ps_dg_dgsclt), .ps_dg_mdfy(ps_dg_mdfy),
        .ps_dg_iadd(ps_dg_iadd), .ps_dg_madd(ps_dg_madd),
        .ps_dg_imm_en(ps_dg_imm_en), .ps_dg_imm(ps_dg_imm), .ps_dg_brev(ps_dg_brev),
        .ps_dg_wrt_en(ps_dg_wrt_en), .ps_dg_wrt_add(ps_dg_wrt_add),
        .ps_dg_rd_add(ps_dg_rd_add), .bc_dt_out(bc_dt_out), .dg_bc_dt(dg_bc_dt),
        .dg_dm_add(dg_dm_add), .dg_dm_vld(dg_dm_vld),
        .dg_pm_add(dg_pm_add), .dg_pm_vld(dg_pm_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ps_dg_en = 0; ps_dg_dgsclt = 0; ps_dg_mdfy = 0; ps_dg_iadd = '0;
        ps_dg_madd = '0; ps_dg_imm_en = 0; ps_dg_imm = '0; ps_dg_brev = 0;
        ps_dg_wrt_en = 0; ps_dg_wrt_add = '0; bc_dt_out = '0;
    endtask

    task automatic wr(input logic [1:0] t, input logic b, input logic [IW-1:0] i,
                      input logic [AW-1:0] d);
        ps_dg_wrt_en = 1; ps_dg_wrt_add = {t, b, i}; bc_dt_out = d;
        @(negedge clk);
        ps_dg_wrt_en = 0;
    endtask

    task automatic req(input logic sel, input logic pre, input logic [IW-1:0] ia,
                       input logic [IW-1:0] ma, input logic ie, input logic [AW-1:0] imm,
                       input logic br);
        ps_dg_en = 1; ps_dg_dgsclt = sel; ps_dg_mdfy = pre; ps_dg_iadd = ia;
        ps_dg_madd = ma; ps_dg_imm_en = ie; ps_dg_imm = imm; ps_dg_brev = br;
        @(negedge clk);
        ps_dg_en = 0; ps_dg_imm_en = 0; ps_dg_brev = 0;
    endtask

    task automatic rd(input string tag, input logic [1:0] t, input logic b,
                      input logic [IW-1:0] i, input logic [AW-1:0] exp);
        ps_dg_rd_add = {t, b, i};
        #1;
        check(tag, dg_bc_dt, exp);
    endtask

    initial begin
        idle();
        ps_dg_rd_add = '0;
        rst_n = 0;
        // request and write during reset must be discarded
        ps_dg_en = 1; ps_dg_mdfy = 0;
        ps_dg_wrt_en = 1; ps_dg_wrt_add = {T_I, 1'b0, 3'd0}; bc_dt_out = 16'h0055;
        @(negedge clk);
        @(negedge clk);
        idle();
        rst_n = 1;
        @(negedge clk);
        check("rst_dm_vld", {15'd0, dg_dm_vld}, 16'h0);
        check("rst_pm_vld", {15'd0, dg_pm_vld}, 16'h0);
        check("rst_dm_add", dg_dm_add, 16'h0);
        check("rst_pm_add", dg_pm_add, 16'h0);
        for (int t = 0; t < 4; t++)
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NREG; i++)
                    rd("rst_reg", t[1:0], b[0], i[IW-1:0], 16'h0);

        // bank 0 circular wrap upward
        wr(T_B, 0, 0, 16'h0100);
        rd("b_loads_i", T_I, 0, 0, 16'h0100);
        wr(T_L, 0, 0, 16'h0008);
        wr(T_I, 0, 0, 16'h0106);
        wr(T_M, 0, 0, 16'h0003);
        req(0, 0, 0, 0, 0, 16'h0, 0);
        check("post_dm_add", dg_dm_add, 16'h0106);
        check("post_dm_vld", {15'd0, dg_dm_vld}, 16'h1);
        check("post_pm_vld", {15'd0, dg_pm_vld}, 16'h0);
        rd("wrap_up_i0", T_I, 0, 0, 16'h0101);

        // immediate negative modifier wraps downward
        req(0, 0, 0, 0, 1, 16'hFFFD, 0);
        check("imm_dm_add", dg_dm_add, 16'h0101);
        rd("wrap_dn_i0", T_I, 0, 0, 16'h0106);

        // bank 1 linear, premodify
        wr(T_I, 1, 0, 16'h0010);
        wr(T_M, 1, 0, 16'h0004);
        req(1, 1, 0, 0, 0, 16'h0, 0);
        check("pre_pm_add", dg_pm_add, 16'h0014);
        check("pre_pm_vld", {15'd0, dg_pm_vld}, 16'h1);
        check("pre_dm_vld", {15'd0, dg_dm_vld}, 16'h0);
        check("pre_dm_hold", dg_dm_add, 16'h0101);
        rd("pre_i1_keep", T_I, 1, 0, 16'h0010);
        @(negedge clk);
        check("idle_pm_vld", {15'd0, dg_pm_vld}, 16'h0);
        check("idle_pm_hold", dg_pm_add, 16'h0014);

        // linear overflow
        wr(T_I, 1, 0, 16'hFFFF);
        wr(T_M, 1, 1, 16'h0002);
        req(1, 0, 0, 1, 0, 16'h0, 0);
        check("ovf_pm_add", dg_pm_add, 16'hFFFF);
        rd("ovf_i1", T_I, 1, 0, 16'h0001);

        // bit-reversed output, stored I not reversed
        wr(T_I, 0, 1, 16'h0001);
        wr(T_M, 0, 1, 16'h0001);
        req(0, 0, 1, 1, 0, 16'h0, 1);
        check("brev_dm_add", dg_dm_add, 16'h8000);
        rd("brev_i", T_I, 0, 1, 16'h0002);

        // bus write beats postmodify on the same I
        wr(T_L, 0, 0, 16'h0000);
        wr(T_I, 0, 0, 16'h0050);
        wr(T_M, 0, 2, 16'h0001);
        ps_dg_wrt_en = 1; ps_dg_wrt_add = {T_I, 1'b0, 3'd0}; bc_dt_out = 16'h0200;
        req(0, 0, 0, 2, 0, 16'h0, 0);
        ps_dg_wrt_en = 0;
        check("coll_dm_add", dg_dm_add, 16'h0050);
        rd("coll_i0", T_I, 0, 0, 16'h0200);

        // combinational read bypass
        ps_dg_wrt_en = 1; ps_dg_wrt_add = {T_I, 1'b0, 3'd0}; bc_dt_out = 16'h1234;
        rd("bypass", T_I, 0, 0, 16'h1234);
        @(negedge clk);
        ps_dg_wrt_en = 0;
        rd("bypass_commit", T_I, 0, 0, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dag_circ_top.md
Name: dag_circ_top

Overview:
Parametrised data address generator with two banks: bank 0 drives DM addresses, bank 1 drives PM addresses. Each bank holds NREG index (I), modify (M), length (L) and base (B) registers. It adds circular-buffer wrap, an immediate modifier, bit-reversed addressing, and registered address outputs with valid strobes. The register file is accessed from the bus through ps_dg_wrt_add / ps_dg_rd_add.

Parameters:
AW, 16, address/data width; all registers and buses are AW bits.
NREG, 8, registers of each type per bank; power of 2, minimum 2.
IW, $clog2(NREG), index width (derived).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  synchronous active-low reset.
ps_dg_en  input  1  address request this cycle.
ps_dg_dgsclt  input  1  bank select: 0 = DM/bank 0, 1 = PM/bank 1.
ps_dg_mdfy  input  1  1 = premodify (no update), 0 = postmodify (I updated).
ps_dg_iadd  input  IW  I register index.
ps_dg_madd  input  IW  M register index.
ps_dg_imm_en  input  1  use ps_dg_imm instead of M[madd].
ps_dg_imm  input  AW  signed immediate modifier.
ps_dg_brev  input  1  bit-reverse the output address.
ps_dg_wrt_en  input  1  register-file write strobe.
ps_dg_wrt_add  input  3+IW  {type[1:0], bank, index}; type 00=M, 01=I, 10=L, 11=B.
ps_dg_rd_add  input  3+IW  register-file read address, same encoding.
bc_dt_out  input  AW  bus write data.
dg_bc_dt  output  AW  register-file read data (combinational).
dg_dm_add  output  AW  registered DM address.
dg_dm_vld  output  1  dg_dm_add valid.
dg_pm_add  output  AW  registered PM address.
dg_pm_vld  output  1  dg_pm_add valid.

Behaviour:
- Reset (rst_n=0 at posedge): all I/M/L/B, dg_dm_add, dg_pm_add = 0; both vld = 0. A request or write in a reset cycle is discarded.
- Definitions, all values sampled pre-edge, k = {dgsclt, iadd}:
  - mod = ps_dg_imm_en ? ps_dg_imm : M[dgsclt][madd], signed two's complement.
  - sum = I + sign-extended mod, computed at AW+1 bits.
- Circular wrap wrap(sum):
  - if L = 0: sum mod 2^AW (linear).
  - else if mod >= 0 and sum >= B+L (AW+1-bit compare): sum - L.
  - else if mod < 0 and sum < B: sum + L.
  - else: sum.
  - Exactly one correction is applied. |mod| > L yields the once-corrected value; no fault is raised.
- Request (ps_dg_en=1):
  - premodify: addr = wrap(sum); I unchanged.
  - postmodify: addr = I; I[k] <= wrap(sum).
  - If ps_dg_brev, the output is addr with bits [AW-1:0] reversed. The stored I is never reversed.
- Latency: the address appears on the selected bank's output the cycle after the request, with its vld = 1 for one cycle. The unselected output holds its value with vld = 0. With no request, both vld = 0 and the addresses hold.
- Register write (ps_dg_wrt_en=1): the addressed register <= bc_dt_out.
  - Writing B also loads the same bank/index I with bc_dt_out.
  - A write to M/L/B in the same cycle as a request does not affect that request (old values used).
- Collision: a write to I[k] (direct, or via a B write) in the same cycle as a postmodify of I[k] — bus write wins; the postmodify update is dropped. The output address still uses the old I.
- Read: dg_bc_dt = register at ps_dg_rd_add.
  - Bypass: if ps_dg_wrt_en and wrt_add == rd_add, dg_bc_dt = bc_dt_out.
  - A B-write targets only the B address for bypass purposes.
  - Reading an I being postmodified returns the pre-update value.
- Back-to-back requests on the same I see the updated value each cycle (one update per cycle).

Test Plan:
- Reset, then read every register -> all 0; drive request at rst_n=0 -> no vld, I unchanged.
- Bank 0: B0=0x0100 (I0 becomes 0x0100), L0=8, write I0=0x0106, M0=3, postmodify -> next cycle dg_dm_add=0x0106, dg_dm_vld=1; I0=0x0101.
- Bank 0: I0=0x0101, immediate 0xFFFD, postmodify, L0=8, B0=0x0100 -> dg_dm_add=0x0101; I0=0x0106.
- Bank 1: L=0, I=0x0010, M=4, premodify -> dg_pm_add=0x0014, dg_pm_vld=1, I stays 0x0010. Then I=0xFFFF, M=2 postmodify -> I=0x0001.
- brev=1, bank 0, I=0x0001, postmodify M=1 -> dg_dm_add=0x8000; I0=0x0002.
- Same cycle: write I0=0x0200 and postmodify I0 (I0=0x0050, M=1) -> dg_dm_add=0x0050, I0=0x0200. Read I0 with wrt_add==rd_add, bc_dt_out=0x1234 -> dg_bc_dt=0x1234 combinationally.
